// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// state encoding, opcode/funct values and ALU select codes.
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_TRAP    = 4'd13,
        S_FAULT   = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Instruction-register, memory-handshake and datapath-control bundle
// between the multi-cycle controller and its datapath.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_sel;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       fault;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_sel, reg_dst, mem_to_reg, reg_write,
               illegal_op, fault, state_o
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_sel, reg_dst, mem_to_reg, reg_write,
               illegal_op, fault, state_o
    );
endinterface

// File: rtl/mips_mc_alu_decoder.sv
// Combinational ALU control: maps the controller's alu_op (and funct for
// R-type) to the 4-bit ALU function select.
module mips_mc_alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_sel
);

    always_comb begin
        alu_sel = SEL_ADD;
        case (alu_op)
            ALU_ADD: alu_sel = SEL_ADD;
            ALU_SUB: alu_sel = SEL_SUB;
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_sel = SEL_ADD;
                    FN_SUB:  alu_sel = SEL_SUB;
                    FN_AND:  alu_sel = SEL_AND;
                    FN_OR:   alu_sel = SEL_OR;
                    FN_SLT:  alu_sel = SEL_SLT;
                    default: alu_sel = SEL_ADD;
                endcase
            end
            default: alu_sel = SEL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory ready handshake, wait-timeout
// fault, optional instruction classes and illegal-opcode trap.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int WAIT_LIMIT  = 15,
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mips_multicycle_control_if.master   bus
);

    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             in_mem_state;
    logic             timeout;
    alu_op_t          alu_op;
    logic             alu_used;
    logic [3:0]       dec_sel;

    assign in_mem_state = is_mem_state(state_reg);
    // A ready in the last allowed cycle still completes the access normally.
    assign timeout = (WAIT_LIMIT > 0) && in_mem_state && !bus.mem_ready
                     && (wait_cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = ENABLE_ADDI ? S_ADDIEX : S_TRAP;
                    OP_J:         state_next = ENABLE_JUMP ? S_JUMP : S_TRAP;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:  state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_next = S_FETCH;
            S_EXECUTE: state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_ADDIWB:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            S_TRAP:    state_next = S_FETCH;
            S_FAULT:   state_next = S_FAULT;
            default:   state_next = S_IDLE;
        endcase
        if (timeout) state_next = S_FAULT;

        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (in_mem_state && !bus.mem_ready)
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    mips_mc_alu_decoder u_alu_decoder (
        .alu_op  (alu_op),
        .funct   (bus.funct),
        .alu_sel (dec_sel)
    );

    // Moore decode; only ir_write/pc_write in FETCH also look at mem_ready.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.illegal_op = 1'b0;
        bus.fault      = 1'b0;
        alu_op         = ALU_ADD;
        alu_used       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                alu_used      = 1'b1;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                alu_used      = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                alu_used      = 1'b1;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                alu_op        = ALU_FUNCT;
                alu_used      = 1'b1;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = 2'b01;
                bus.branch    = 1'b1;
                alu_op        = ALU_SUB;
                alu_used      = 1'b1;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
            end
            S_TRAP:  bus.illegal_op = 1'b1;
            S_FAULT: bus.fault      = 1'b1;
            default: ;
        endcase
        bus.alu_sel = alu_used ? dec_sel : 4'b0000;
    end

    assign bus.state_o = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: two configurations, instruction-level
// reference model producing the expected per-cycle control vector.
module tb_mips_multicycle_control;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                   P_MEMWB = 5, P_MEMWR = 6, P_EXECUTE = 7, P_ALUWB = 8, P_BRANCH = 9,
                   P_ADDIEX = 10, P_ADDIWB = 11, P_JUMP = 12, P_TRAP = 13, P_FAULT = 14;

    localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

    typedef int plan_t[$];

    string pname [15] = '{"IDLE", "FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB", "MEMWR",
                          "EXECUTE", "ALUWB", "BRANCH", "ADDIEX", "ADDIWB", "JUMP",
                          "TRAP", "FAULT"};

    logic       clk;
    logic       rst_a, rst_b;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    bit         sel;
    int         cfg_limit;
    bit         cfg_addi, cfg_jump;
    int         n_cmp, n_bad;

    mips_multicycle_control_if bus_a ();
    mips_multicycle_control_if bus_b ();

    assign bus_a.opcode = opcode;
    assign bus_a.funct = funct;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.opcode = opcode;
    assign bus_b.funct = funct;
    assign bus_b.mem_ready = mem_ready;

    mips_multicycle_control dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a.master));

    mips_multicycle_control #(.WAIT_LIMIT(4), .ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b.master));

    logic [23:0] obs_a, obs_b, obs;
    assign obs_a = {bus_a.state_o, bus_a.mem_req, bus_a.mem_write, bus_a.iord, bus_a.ir_write,
                    bus_a.pc_write, bus_a.branch, bus_a.pc_src, bus_a.alu_src_a, bus_a.alu_src_b,
                    bus_a.alu_sel, bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reg_write,
                    bus_a.illegal_op, bus_a.fault};
    assign obs_b = {bus_b.state_o, bus_b.mem_req, bus_b.mem_write, bus_b.iord, bus_b.ir_write,
                    bus_b.pc_write, bus_b.branch, bus_b.pc_src, bus_b.alu_src_a, bus_b.alu_src_b,
                    bus_b.alu_sel, bus_b.reg_dst, bus_b.mem_to_reg, bus_b.reg_write,
                    bus_b.illegal_op, bus_b.fault};
    assign obs = sel ? obs_b : obs_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] funct_sel(logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expected control vector for one cycle spent in phase p.
    function automatic logic [23:0] exp_vec(int p, logic rdy, logic [5:0] fn);
        logic mreq, mw, iord, irw, pcw, br, asa, rdst, m2r, rw, ill, flt;
        logic [1:0] psrc, asb;
        logic [3:0] asel;
        {mreq, mw, iord, irw, pcw, br, asa, rdst, m2r, rw, ill, flt} = '0;
        psrc = 2'b00; asb = 2'b00; asel = 4'b0000;
        case (p)
            P_FETCH:   begin mreq = 1; asb = 2'b01; asel = 4'b0010; irw = rdy; pcw = rdy; end
            P_DECODE:  begin asb = 2'b11; asel = 4'b0010; end
            P_MEMADR:  begin asa = 1; asb = 2'b10; asel = 4'b0010; end
            P_MEMRD:   begin mreq = 1; iord = 1; end
            P_MEMWB:   begin m2r = 1; rw = 1; end
            P_MEMWR:   begin mreq = 1; mw = 1; iord = 1; end
            P_EXECUTE: begin asa = 1; asel = funct_sel(fn); end
            P_ALUWB:   begin rdst = 1; rw = 1; end
            P_BRANCH:  begin asa = 1; asel = 4'b0110; psrc = 2'b01; br = 1; end
            P_ADDIEX:  begin asa = 1; asb = 2'b10; asel = 4'b0010; end
            P_ADDIWB:  rw = 1;
            P_JUMP:    begin psrc = 2'b10; pcw = 1; end
            P_TRAP:    ill = 1;
            P_FAULT:   flt = 1;
            default: ;
        endcase
        return {4'(p), mreq, mw, iord, irw, pcw, br, psrc, asa, asb, asel, rdst, m2r, rw, ill, flt};
    endfunction

    // Sequence of phases an instruction walks through, zero-wait.
    function automatic plan_t plan_for(logic [5:0] op);
        plan_t q;
        q.push_back(P_FETCH);
        q.push_back(P_DECODE);
        case (op)
            T_RTYPE: begin q.push_back(P_EXECUTE); q.push_back(P_ALUWB); end
            T_LW:    begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
            T_SW:    begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
            T_BEQ:   q.push_back(P_BRANCH);
            T_ADDI:  if (cfg_addi) begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
                     else q.push_back(P_TRAP);
            T_J:     if (cfg_jump) q.push_back(P_JUMP); else q.push_back(P_TRAP);
            default: q.push_back(P_TRAP);
        endcase
        return q;
    endfunction

    task automatic check(input string tag, input logic [23:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    task automatic one_cycle(input int p, input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
        check(pname[p], exp_vec(p, rdy, funct));
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input int p, input int waits, inout bit faulted, inout int cycles);
        bit timed;
        int nr;
        timed = (cfg_limit > 0) && (waits >= cfg_limit);
        nr = timed ? cfg_limit : waits;
        for (int i = 0; i < nr; i++) begin
            one_cycle(p, 1'b0);
            cycles++;
        end
        if (timed) faulted = 1'b1;
        else begin
            one_cycle(p, 1'b1);
            cycles++;
        end
    endtask

    task automatic do_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("reset", exp_vec(P_IDLE, 1'b0, 6'd0));
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        one_cycle(P_IDLE, 1'($urandom));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, output bit faulted);
        plan_t plan;
        int cycles;
        int p;
        plan = plan_for(op);
        opcode = op;
        funct = fn;
        cycles = 0;
        faulted = 1'b0;
        foreach (plan[i]) begin
            p = plan[i];
            if (p == P_FETCH) mem_phase(p, fw, faulted, cycles);
            else if (p == P_MEMRD || p == P_MEMWR) mem_phase(p, mw, faulted, cycles);
            else begin
                one_cycle(p, 1'($urandom));
                cycles++;
            end
            if (faulted) break;
        end
        if (faulted)
            for (int k = 0; k < 3; k++) one_cycle(P_FAULT, 1'($urandom));
        $display("dut=%s op=%b funct=%b fetch_wait=%0d mem_wait=%0d cycles=%0d%s",
                 sel ? "B" : "A", op, fn, fw, mw, cycles, faulted ? " -> FAULT" : "");
    endtask

    function automatic logic [5:0] rand_op();
        int k;
        logic [5:0] op;
        k = $urandom_range(0, 7);
        case (k)
            0: op = T_RTYPE;
            1: op = T_LW;
            2: op = T_SW;
            3: op = T_BEQ;
            4: op = T_ADDI;
            5: op = T_J;
            6: op = 6'b111111;
            default: begin
                op = 6'($urandom);
                while (op inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J}) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    function automatic logic [5:0] rand_funct();
        logic [5:0] t [5];
        t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if ($urandom_range(0, 5) == 5) return 6'($urandom);
        return t[$urandom_range(0, 4)];
    endfunction

    initial begin
        bit f;
        n_cmp = 0; n_bad = 0;
        sel = 1'b0; cfg_limit = 15; cfg_addi = 1'b1; cfg_jump = 1'b1;
        rst_a = 1'b0; rst_b = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;

        // Configuration A: defaults.
        do_reset();
        run_instr(T_LW, rand_funct(), 0, 0, f);
        run_instr(T_RTYPE, 6'b101010, 0, 0, f);
        run_instr(T_SW, rand_funct(), 0, 3, f);
        repeat (40) run_instr(rand_op(), rand_funct(), $urandom_range(0, 3), $urandom_range(0, 3), f);

        // Reset asserted while a store is waiting on memory.
        opcode = T_SW; funct = '0;
        one_cycle(P_FETCH, 1'b1);
        one_cycle(P_DECODE, 1'b0);
        one_cycle(P_MEMADR, 1'b1);
        one_cycle(P_MEMWR, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        check("MEMWR_before_rst", exp_vec(P_MEMWR, 1'b0, funct));
        #2 rst_a = 1'b0;
        #1 check("async_rst", exp_vec(P_IDLE, 1'b0, 6'd0));
        $display("dut=A sw aborted by reset in MEMWR");
        do_reset();
        run_instr(T_BEQ, rand_funct(), 0, 0, f);

        // Configuration B: WAIT_LIMIT=4, addi and j disabled.
        sel = 1'b1; cfg_limit = 4; cfg_addi = 1'b0; cfg_jump = 1'b0;
        do_reset();
        run_instr(T_ADDI, rand_funct(), 0, 0, f);
        run_instr(T_J, rand_funct(), 0, 0, f);
        run_instr(6'b111111, rand_funct(), 0, 0, f);
        run_instr(T_RTYPE, 6'b100010, 0, 0, f);
        run_instr(T_LW, rand_funct(), 3, 0, f);
        run_instr(T_SW, rand_funct(), 0, 3, f);
        run_instr(T_LW, rand_funct(), 10, 0, f);
        do_reset();
        run_instr(T_LW, rand_funct(), 0, 6, f);
        do_reset();
        repeat (15) begin
            run_instr(rand_op(), rand_funct(), $urandom_range(0, 5), $urandom_range(0, 5), f);
            if (f) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
